// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: control inputs and serial/status outputs of the pattern transmitter
// Signals (driver/master side view):
//   start_i    request to send one pattern
//   repeat_i   re-send the pattern back-to-back when high at the end of the last bit
//   pattern_i  LEN-bit pattern, sent MSB first
//   w_o        serial data bit
//   w_valid_o  w_o carries a pattern bit
//   busy_o     transmitter is shifting
//   done_o     one-cycle pulse after the last bit period of each pattern
//   bit_idx_o  index of the bit currently on w_o
//   clk_tick_o toggles at every bit-period boundary
interface seq_pattern_tx_if #(parameter int LEN = 5);
  logic           start_i;
  logic           repeat_i;
  logic [LEN-1:0] pattern_i;
  logic           w_o;
  logic           w_valid_o;
  logic           busy_o;
  logic           done_o;
  logic [2:0]     bit_idx_o;
  logic           clk_tick_o;
  modport master (
    output start_i, repeat_i, pattern_i,
    input  w_o, w_valid_o, busy_o, done_o, bit_idx_o, clk_tick_o
  );
  modport slave (
    input  start_i, repeat_i, pattern_i,
    output w_o, w_valid_o, busy_o, done_o, bit_idx_o, clk_tick_o
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial transmitter of a LEN-bit pattern (MSB first) with optional back-to-back repeat
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    seq_pattern_tx_if.slave (start/repeat/pattern in; w, w_valid, busy, done, bit_idx, clk_tick out)
// Configuration:
//   SEQ_TX_PRESCALE_EN defined   -> each bit lasts PRESCALE clk cycles (29-bit prescale counter)
//   SEQ_TX_PRESCALE_EN undefined -> each bit lasts one clk cycle, PRESCALE has no effect
module seq_pattern_tx #(
  parameter int LEN      = 5,
  parameter int PRESCALE = 400_000_000
) (
  input logic           clk,
  input logic           reset,
  seq_pattern_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  state_t         state_q, state_d;
  logic [LEN-1:0] sh_q, sh_d;
  logic [2:0]     idx_q, idx_d;
  logic           w_q, w_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           tick_q, tick_d;
  logic           bit_end;
`ifdef SEQ_TX_PRESCALE_EN
  logic [28:0] cnt_q, cnt_d;
  assign bit_end = cnt_q == 29'(PRESCALE - 1);
  // counter only runs while shifting, so every pattern starts on a fresh period
  assign cnt_d = (state_q != SHIFT || bit_end) ? '0 : cnt_q + 29'd1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  // legal PRESCALE is always >= 1, so every cycle ends a bit period
  assign bit_end = PRESCALE >= 1;
`endif
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    w_d     = w_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tick_d  = tick_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        state_d = SHIFT;
        sh_d    = bus.pattern_i;
        idx_d   = 3'(LEN - 1);
        w_d     = bus.pattern_i[LEN-1];
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      SHIFT: if (bit_end) begin
        tick_d = ~tick_q;
        if (idx_q != 3'd0) begin
          // captured copy shifts left so the next bit is always just below the MSB
          idx_d = idx_q - 3'd1;
          sh_d  = sh_q << 1;
          w_d   = sh_q[LEN-2];
        end else if (bus.repeat_i) begin
          sh_d   = bus.pattern_i;
          idx_d  = 3'(LEN - 1);
          w_d    = bus.pattern_i[LEN-1];
          done_d = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          w_d     = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        sh_d    = '0;
        idx_d   = 3'd0;
        w_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= 3'd0;
      w_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
    end
  assign bus.w_o        = w_q;
  assign bus.w_valid_o  = valid_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.bit_idx_o  = idx_q;
  assign bus.clk_tick_o = tick_q;
endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter LEN, default 5, serial pattern length in bits (2..8).
REQ-002 SHALL have parameter PRESCALE, default 400_000_000, clk cycles per bit period (1..2^29-1).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to transmit one pattern; sampled only in IDLE.
REQ-006 SHALL have port repeat  input  1  when high at end of last bit, re-send pattern back-to-back.
REQ-007 SHALL have port pattern  input  LEN  bits to send, MSB first; captured at start and at each repeat wrap.
REQ-008 SHALL have port w  output  1  serial data bit, drives the 10010 detector input.
REQ-009 SHALL have port w_valid  output  1  high while w carries a pattern bit.
REQ-010 SHALL have port busy  output  1  high in SHIFT state.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the final bit period of each pattern.
REQ-012 SHALL have port bit_idx  output  3  index of the bit currently on w (LEN-1 down to 0).
REQ-013 SHALL have port clk_tick  output  1  toggles at every bit-period boundary (board LED).

Function
REQ-014 SHALL implement states IDLE, SHIFT, DONE, all registered, with outputs registered.
REQ-015 In IDLE with start=1 at a rising edge, SHALL capture pattern, enter SHIFT next cycle with w=pattern[LEN-1], bit_idx=LEN-1, w_valid=1, busy=1, prescale counter=0.
REQ-016 In IDLE, w=0, w_valid=0, busy=0, done=0; start=0 keeps IDLE.
REQ-017 Each bit SHALL be held for exactly one bit period; period ends when prescale counter reaches PRESCALE-1, then counter returns to 0.
REQ-018 At a period end with bit_idx>0, SHALL decrement bit_idx, shift next lower captured bit onto w, toggle clk_tick.
REQ-019 At the period end of bit_idx=0 with repeat=0, SHALL enter DONE: done=1, w=0, w_valid=0, busy=0, toggle clk_tick; next cycle IDLE, done=0.
REQ-020 At the period end of bit_idx=0 with repeat=1, SHALL stay in SHIFT, recapture pattern, set bit_idx=LEN-1, w=new pattern[LEN-1], pulse done for that one cycle, toggle clk_tick; no gap cycle.
REQ-021 start in SHIFT or DONE SHALL be ignored (no restart, no queuing).
REQ-022 Changes to pattern outside capture points SHALL NOT affect w.
REQ-023 Illegal state encoding SHALL recover to IDLE on the next clock.

Reset
REQ-024 reset=0 SHALL immediately force IDLE, w=0, w_valid=0, busy=0, done=0, bit_idx=0, clk_tick=0, prescale counter=0, captured pattern=0.
REQ-025 Reset asserted mid-pattern SHALL abort transmission without a done pulse; after release block waits for a new start.

Configuration
REQ-026 Macro SEQ_TX_PRESCALE_EN defined: bit period = PRESCALE clk cycles, 29-bit prescale counter present.
REQ-027 Macro SEQ_TX_PRESCALE_EN undefined: PRESCALE ignored, no counter, bit period = 1 clk cycle (simulation mode); all other behaviour identical.

Verification
REQ-028 Macro off, pattern=5'b10010, pulse start 1 cycle -> w sequence 1,0,0,1,0 on 5 consecutive cycles, bit_idx 4..0, done=1 on the 6th cycle, then IDLE.
REQ-029 Macro off, repeat=1, pattern=5'b10010 -> w = 1001010010... continuous, w_valid never drops, done pulses every 5 cycles; drop repeat -> ends after current pattern.
REQ-030 Macro on, PRESCALE=4, pattern=5'b11001 -> each bit held 4 cycles, clk_tick toggles 5 times, done after 20 SHIFT cycles.
REQ-031 Start asserted at bit_idx=2 with new pattern=5'b01111 -> ignored; original pattern completes unchanged.
REQ-032 reset=0 during bit_idx=3 -> outputs zero asynchronously, no done pulse; new start after release sends full pattern from bit_idx=4.
REQ-033 Loop output into 10010 detector, repeat=1, pattern=5'b10010 -> detector z asserts once per pattern after the first 5 bits (overlap check).
